// File: rtl/ibex_pkg.sv
// ibex_pkg: shared LSU access types, FSM states and byte-enable helpers.
package ibex_pkg;
    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID_MIS_GNTS_DONE,
        WAIT_RVALID
    } ls_fsm_e;

    typedef struct packed {
        logic [31:0] addr;
        lsu_type_e   lsu_type;
        logic        sign_ext;
        logic        we;
    } lsu_dp_t;

    function automatic logic [3:0] type_mask(lsu_type_e t);
        return t == LSU_WORD ? 4'b1111 : t == LSU_HALF ? 4'b0011 : 4'b0001;
    endfunction

    function automatic logic is_misaligned(lsu_type_e t, logic [1:0] off);
        return (t == LSU_WORD && off != 2'b00) || (t == LSU_HALF && off == 2'b11);
    endfunction
endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// ibex_lsu_rdata_align: merges split responses, selects the addressed bytes and extends them.
module ibex_lsu_rdata_align import ibex_pkg::*; (
    input  logic [31:0] rdata_i,
    input  logic [23:0] rdata_q_i,
    input  logic        split_i,
    input  logic [1:0]  off_i,
    input  lsu_type_e   type_i,
    input  logic        sign_ext_i,
    output logic [31:0] rdata_o
);
    logic [31:0] lo, win;
    // Unsplit accesses rotate within one word; split ones pull upper bytes from the first part.
    assign lo  = split_i ? {rdata_q_i, 8'h00} : rdata_i;
    assign win = off_i == 2'd0 ? lo :
                 off_i == 2'd1 ? {rdata_i[7:0],  lo[31:8]}  :
                 off_i == 2'd2 ? {rdata_i[15:0], lo[31:16]} :
                                 {rdata_i[23:0], lo[31:24]};
    always_comb
        rdata_o = type_i == LSU_WORD ? win :
                  type_i == LSU_HALF ? {{16{sign_ext_i & win[15]}}, win[15:0]} :
                                       {{24{sign_ext_i & win[7]}}, win[7:0]};
endmodule

// File: rtl/ibex_lsu_split.sv
// ibex_lsu_split: load/store unit that splits misaligned accesses into two aligned
// OBI transactions and returns aligned, extended load data to writeback.
module ibex_lsu_split import ibex_pkg::*; #(
    parameter bit ResetAll       = 1'b0,
    parameter bit WritebackStage = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rdata_valid_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        lsu_req_done_o,
    output logic [31:0] lsu_addr_last_o,
    output logic        busy_o
);
    ls_fsm_e     ls_q, ls_d;
    lsu_dp_t     dp_q, dp_d;
    logic [23:0] rdata_q;
    logic [31:0] addr_last_q, addr_last_d, addr_bus, wdata_rot, rdata_al;
    logic        split_q, split_d, err_q, err_d;
    logic        req, cap, rd_en, mis, final_gnt, final_rvalid, err_any;
    logic [1:0]  off;
    lsu_type_e   typ;
    logic [7:0]  be_ext;

    // split_q marks that the first part is granted and the second part is in flight.
    assign mis       = is_misaligned(lsu_type_e'(lsu_type_i), adder_result_ex_i[1:0]);
    assign off       = split_q ? dp_q.addr[1:0] : adder_result_ex_i[1:0];
    assign typ       = split_q ? dp_q.lsu_type : lsu_type_e'(lsu_type_i);
    assign be_ext    = {4'b0000, type_mask(typ)} << off;
    assign addr_bus  = split_q ? {dp_q.addr[31:2] + 30'd1, 2'b00} : {adder_result_ex_i[31:2], 2'b00};
    assign wdata_rot = off == 2'd0 ? lsu_wdata_i :
                       off == 2'd1 ? {lsu_wdata_i[23:0], lsu_wdata_i[31:24]} :
                       off == 2'd2 ? {lsu_wdata_i[15:0], lsu_wdata_i[31:16]} :
                                     {lsu_wdata_i[7:0],  lsu_wdata_i[31:8]};
    assign dp_d      = '{addr: adder_result_ex_i, lsu_type: lsu_type_e'(lsu_type_i),
                         sign_ext: lsu_sign_ext_i, we: lsu_we_i};

    always_comb begin
        ls_d         = ls_q;
        split_d      = split_q;
        err_d        = err_q;
        addr_last_d  = addr_last_q;
        req          = 1'b0;
        rd_en        = 1'b0;
        final_gnt    = 1'b0;
        final_rvalid = 1'b0;
        unique case (ls_q)
            IDLE: begin
                req       = lsu_req_i;
                final_gnt = lsu_req_i & data_gnt_i & ~mis;
                if (lsu_req_i)
                    ls_d = data_gnt_i ? (mis ? WAIT_RVALID_MIS : WAIT_RVALID) : (mis ? WAIT_GNT_MIS : WAIT_GNT);
            end
            WAIT_GNT_MIS: begin
                req = 1'b1;
                if (data_gnt_i) ls_d = WAIT_RVALID_MIS;
            end
            WAIT_RVALID_MIS: begin
                req       = 1'b1;
                final_gnt = data_gnt_i;
                rd_en     = data_rvalid_i;
                ls_d      = data_rvalid_i ? (data_gnt_i ? WAIT_RVALID : WAIT_GNT) :
                                            (data_gnt_i ? WAIT_RVALID_MIS_GNTS_DONE : WAIT_RVALID_MIS);
            end
            WAIT_GNT: begin
                req       = 1'b1;
                final_gnt = data_gnt_i;
                if (data_gnt_i) ls_d = WAIT_RVALID;
            end
            WAIT_RVALID_MIS_GNTS_DONE: begin
                rd_en = data_rvalid_i;
                if (data_rvalid_i) ls_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                final_rvalid = data_rvalid_i;
                if (data_rvalid_i) ls_d = IDLE;
            end
            default: ls_d = IDLE;
        endcase
        cap = req & data_gnt_i & ~split_q;
        if (cap) split_d = mis;
        if (req & data_gnt_i) addr_last_d = split_q ? addr_bus : adder_result_ex_i;
        if (rd_en) err_d = err_q | data_err_i;
        if (final_rvalid) begin
            split_d = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ls_q        <= IDLE;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            addr_last_q <= '0;
        end else begin
            ls_q        <= ls_d;
            split_q     <= split_d;
            err_q       <= err_d;
            addr_last_q <= addr_last_d;
        end
    end

    if (ResetAll) begin : g_dp_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dp_q    <= '0;
                rdata_q <= '0;
            end else begin
                if (cap) dp_q <= dp_d;
                if (rd_en) rdata_q <= data_rdata_i[31:8];
            end
        end
    end else begin : g_dp_nrst
        always_ff @(posedge clk_i) begin
            if (cap) dp_q <= dp_d;
            if (rd_en) rdata_q <= data_rdata_i[31:8];
        end
    end

    ibex_lsu_rdata_align u_align (
        .rdata_i    (data_rdata_i),
        .rdata_q_i  (rdata_q),
        .split_i    (split_q),
        .off_i      (dp_q.addr[1:0]),
        .type_i     (dp_q.lsu_type),
        .sign_ext_i (dp_q.sign_ext),
        .rdata_o    (rdata_al)
    );

    assign err_any           = err_q | data_err_i;
    assign data_req_o        = req;
    assign data_addr_o       = req ? addr_bus : '0;
    assign data_be_o         = req ? (split_q ? be_ext[7:4] : be_ext[3:0]) : '0;
    assign data_we_o         = req & (split_q ? dp_q.we : lsu_we_i);
    assign data_wdata_o      = req ? wdata_rot : '0;
    assign lsu_resp_valid_o  = final_rvalid;
    assign lsu_resp_err_o    = final_rvalid & err_any;
    assign lsu_rdata_valid_o = final_rvalid & ~dp_q.we & ~err_any;
    assign lsu_rdata_o       = lsu_rdata_valid_o ? rdata_al : '0;
    assign lsu_req_done_o    = WritebackStage ? final_gnt : final_rvalid;
    assign lsu_addr_last_o   = addr_last_q;
    assign busy_o            = ls_q != IDLE;
endmodule

// File: tb/tb_ibex_lsu_split.sv
// tb_ibex_lsu_split: table-driven and randomized checks of the split LSU against a byte-level model.
module tb_ibex_lsu_split;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        lsu_req_i = 0, lsu_we_i = 0, lsu_sign_ext_i = 0;
    logic [1:0]  lsu_type_i = 0;
    logic [31:0] lsu_wdata_i = 0, adder_result_ex_i = 0, data_rdata_i = 0;
    logic        data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0;
    logic        data_req_o, data_we_o, lsu_rdata_valid_o, lsu_resp_valid_o, lsu_resp_err_o, lsu_req_done_o, busy_o;
    logic [31:0] data_addr_o, data_wdata_o, lsu_rdata_o, lsu_addr_last_o;
    logic [3:0]  data_be_o;
    int errors = 0, checks = 0;

    always #5 clk_i = ~clk_i;

    ibex_lsu_split dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
        .lsu_type_i(lsu_type_i), .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_wdata_i(lsu_wdata_i),
        .adder_result_ex_i(adder_result_ex_i), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rdata_i(data_rdata_i), .lsu_rdata_o(lsu_rdata_o), .lsu_rdata_valid_o(lsu_rdata_valid_o),
        .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_err_o(lsu_resp_err_o),
        .lsu_req_done_o(lsu_req_done_o), .lsu_addr_last_o(lsu_addr_last_o), .busy_o(busy_o)
    );

    typedef struct {
        logic we; logic [1:0] typ; logic sext;
        logic [31:0] addr, wdata, rd0, rd1;
        logic err0, err1; int gd, lat;
    } acc_t;
    typedef struct {
        int parts; logic [31:0] a0, a1, w, rdata; logic [3:0] b0, b1; logic err, rvalid;
    } exp_t;
    typedef struct {
        int parts, nresp, ndone;
        logic req0, stable, busy_end, we0, we1, err, rvalid;
        logic [31:0] a0, a1, w0, w1, rdata; logic [3:0] b0, b1;
    } obs_t;
    typedef struct { acc_t a; exp_t e; } vec_t;

    task automatic chk(input string t, input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", t, n, got, exp);
        end
    endtask

    function automatic acc_t mk_acc(logic we, logic [1:0] typ, logic sext, logic [31:0] addr, logic [31:0] wdata,
                                    logic [31:0] rd0, logic [31:0] rd1, logic err0, logic err1, int gd, int lat);
        acc_t a;
        a.we = we; a.typ = typ; a.sext = sext; a.addr = addr; a.wdata = wdata;
        a.rd0 = rd0; a.rd1 = rd1; a.err0 = err0; a.err1 = err1; a.gd = gd; a.lat = lat;
        return a;
    endfunction

    function automatic exp_t mk_exp(int parts, logic [31:0] a0, logic [31:0] a1, logic [3:0] b0, logic [3:0] b1,
                                    logic [31:0] w, logic [31:0] rdata, logic err, logic rvalid);
        exp_t e;
        e.parts = parts; e.a0 = a0; e.a1 = a1; e.b0 = b0; e.b1 = b1;
        e.w = w; e.rdata = rdata; e.err = err; e.rvalid = rvalid;
        return e;
    endfunction

    // Reference: walk the accessed bytes one at a time and place each into the right bus part.
    function automatic exp_t model(acc_t a);
        exp_t e;
        int sz, off;
        logic [31:0] v;
        sz = a.typ == 2'b00 ? 4 : a.typ == 2'b01 ? 2 : 1;
        off = int'(a.addr[1:0]);
        e.parts = off + sz > 4 ? 2 : 1;
        e.a0 = a.addr & 32'hFFFF_FFFC;
        e.a1 = e.a0 + 32'd4;
        e.b0 = 0; e.b1 = 0; v = 0;
        for (int i = 0; i < sz; i++) begin
            int lane;
            lane = (off + i) % 4;
            if (off + i < 4) begin e.b0[lane] = 1'b1; v[8*i +: 8] = a.rd0[8*lane +: 8]; end
            else begin e.b1[lane] = 1'b1; v[8*i +: 8] = a.rd1[8*lane +: 8]; end
        end
        if (a.sext && sz < 4 && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        e.err = a.err0 | (e.parts == 2 && a.err1);
        e.rvalid = !a.we && !e.err;
        e.rdata = e.rvalid ? v : 32'h0;
        for (int j = 0; j < 4; j++) e.w[8*j +: 8] = a.wdata[8*((j - off + 4) % 4) +: 8];
        return e;
    endfunction

    // Drives one access from a negedge and acts as the bus slave; returns what was observed.
    task automatic run(input acc_t a, output obs_t o);
        int due_q[$], part_q[$];
        int cyc, wait_n, nparts, post;
        bit held;
        logic [68:0] ref_bus;
        o = '{default: 0};
        o.stable = 1'b1;
        cyc = 0; nparts = 0; post = 0; held = 0; ref_bus = 0;
        wait_n = a.gd;
        lsu_we_i = a.we; lsu_type_i = a.typ; lsu_sign_ext_i = a.sext;
        lsu_wdata_i = a.wdata; adder_result_ex_i = a.addr; lsu_req_i = 1'b1;
        while (post < 3 && cyc < 60) begin
            data_rvalid_i = 1'b0; data_err_i = 1'($urandom); data_rdata_i = $urandom; data_gnt_i = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                int p;
                p = part_q.pop_front();
                void'(due_q.pop_front());
                data_rvalid_i = 1'b1;
                data_rdata_i = p != 0 ? a.rd1 : a.rd0;
                data_err_i = p != 0 ? a.err1 : a.err0;
            end
            #1;
            if (cyc == 0) o.req0 = data_req_o;
            if (data_req_o) begin
                if (!held) begin held = 1; ref_bus = {data_addr_o, data_be_o, data_wdata_o, data_we_o}; end
                else if (ref_bus !== {data_addr_o, data_be_o, data_wdata_o, data_we_o}) o.stable = 1'b0;
                if (wait_n > 0) wait_n--;
                else begin
                    data_gnt_i = 1'b1; held = 0; wait_n = a.gd;
                    if (nparts == 0) begin o.a0 = data_addr_o; o.b0 = data_be_o; o.w0 = data_wdata_o; o.we0 = data_we_o; end
                    if (nparts == 1) begin o.a1 = data_addr_o; o.b1 = data_be_o; o.w1 = data_wdata_o; o.we1 = data_we_o; end
                    due_q.push_back(cyc + a.lat);
                    part_q.push_back(nparts);
                    nparts++;
                end
            end
            #1;
            if (lsu_resp_valid_o) begin
                o.nresp++; o.rdata = lsu_rdata_o; o.rvalid = lsu_rdata_valid_o; o.err = lsu_resp_err_o;
            end
            if (lsu_req_done_o) o.ndone++;
            @(negedge clk_i);
            if (o.nresp > 0) begin lsu_req_i = 1'b0; post++; end
            cyc++;
        end
        data_rvalid_i = 1'b0; data_gnt_i = 1'b0; data_err_i = 1'b0;
        o.parts = nparts;
        o.busy_end = busy_o;
    endtask

    task automatic cmp(input string t, input acc_t a, input exp_t e, input obs_t o);
        chk(t, "parts", o.parts, e.parts);
        chk(t, "req0", o.req0, 1);
        chk(t, "stable", o.stable, 1);
        chk(t, "addr0", o.a0, e.a0);
        chk(t, "be0", o.b0, e.b0);
        chk(t, "we0", o.we0, a.we);
        if (e.parts == 2) begin
            chk(t, "addr1", o.a1, e.a1);
            chk(t, "be1", o.b1, e.b1);
            chk(t, "we1", o.we1, a.we);
        end
        if (a.we) begin
            chk(t, "wdata0", o.w0, e.w);
            if (e.parts == 2) chk(t, "wdata1", o.w1, e.w);
        end
        chk(t, "nresp", o.nresp, 1);
        chk(t, "ndone", o.ndone, 1);
        chk(t, "err", o.err, e.err);
        chk(t, "rvalid", o.rvalid, e.rvalid);
        chk(t, "rdata", o.rdata, e.rdata);
        chk(t, "busy_end", o.busy_end, 0);
    endtask

    task automatic zero_outs(input string t);
        chk(t, "req", data_req_o, 0);
        chk(t, "addr", data_addr_o, 0);
        chk(t, "be", data_be_o, 0);
        chk(t, "we", data_we_o, 0);
        chk(t, "wdata", data_wdata_o, 0);
        chk(t, "rdata", lsu_rdata_o, 0);
        chk(t, "flags", {lsu_rdata_valid_o, lsu_resp_valid_o, lsu_resp_err_o, lsu_req_done_o}, 0);
        chk(t, "addr_last", lsu_addr_last_o, 0);
        chk(t, "busy", busy_o, 0);
    endtask

    initial begin
        vec_t tbl[11];
        obs_t o;
        acc_t a;
        tbl[0]  = '{mk_acc(0, 2'b00, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1),
                    mk_exp(1, 32'h100, 32'h104, 4'hF, 4'h0, 0, 32'hDEADBEEF, 0, 1)};
        tbl[1]  = '{mk_acc(0, 2'b00, 0, 32'h102, 0, 32'h11223344, 32'h55667788, 0, 0, 0, 1),
                    mk_exp(2, 32'h100, 32'h104, 4'hC, 4'h3, 0, 32'h77881122, 0, 1)};
        tbl[2]  = '{mk_acc(0, 2'b01, 1, 32'h103, 0, 32'h80AABBCC, 32'h99887701, 0, 0, 0, 1),
                    mk_exp(2, 32'h100, 32'h104, 4'h8, 4'h1, 0, 32'h00000180, 0, 1)};
        tbl[3]  = '{mk_acc(0, 2'b10, 1, 32'h101, 0, 32'h00008000, 0, 0, 0, 0, 1),
                    mk_exp(1, 32'h100, 32'h104, 4'h2, 4'h0, 0, 32'hFFFFFF80, 0, 1)};
        tbl[4]  = '{mk_acc(1, 2'b00, 0, 32'h201, 32'hAABBCCDD, 0, 0, 0, 0, 3, 1),
                    mk_exp(2, 32'h200, 32'h204, 4'hE, 4'h1, 32'hBBCCDDAA, 0, 0, 0)};
        tbl[5]  = '{mk_acc(0, 2'b00, 0, 32'h103, 0, 32'h12345678, 32'h9ABCDEF0, 1, 0, 0, 1),
                    mk_exp(2, 32'h100, 32'h104, 4'h8, 4'h7, 0, 0, 1, 0)};
        tbl[6]  = '{mk_acc(0, 2'b00, 0, 32'hFFFFFFFE, 0, 32'hAABB0000, 32'h0000CCDD, 0, 0, 0, 1),
                    mk_exp(2, 32'hFFFFFFFC, 32'h0, 4'hC, 4'h3, 0, 32'hCCDDAABB, 0, 1)};
        tbl[7]  = '{mk_acc(0, 2'b01, 0, 32'h102, 0, 32'h80013344, 0, 0, 0, 0, 2),
                    mk_exp(1, 32'h100, 32'h104, 4'hC, 4'h0, 0, 32'h00008001, 0, 1)};
        tbl[8]  = '{mk_acc(1, 2'b01, 0, 32'h103, 32'h00001234, 0, 0, 0, 0, 1, 1),
                    mk_exp(2, 32'h100, 32'h104, 4'h8, 4'h1, 32'h34000012, 0, 0, 0)};
        tbl[9]  = '{mk_acc(0, 2'b01, 1, 32'h303, 0, 32'hFF000000, 32'h000000FF, 0, 1, 0, 2),
                    mk_exp(2, 32'h300, 32'h304, 4'h8, 4'h1, 0, 0, 1, 0)};
        tbl[10] = '{mk_acc(0, 2'b00, 0, 32'h101, 0, 32'h44332211, 32'h88776655, 0, 0, 1, 2),
                    mk_exp(2, 32'h100, 32'h104, 4'hE, 4'h1, 0, 32'h55443322, 0, 1)};

        #12 zero_outs("reset");
        @(negedge clk_i) rst_ni = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 11; i++) begin
            run(tbl[i].a, o);
            cmp($sformatf("vec%0d", i), tbl[i].a, tbl[i].e, o);
        end

        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b00; adder_result_ex_i = 32'h102; data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        #1 chk("midrst", "busy_before", busy_o, 1);
        lsu_req_i = 1'b0; adder_result_ex_i = 0; lsu_wdata_i = 0; rst_ni = 1'b0;
        #1 zero_outs("midrst");
        @(negedge clk_i) rst_ni = 1'b1;
        @(negedge clk_i);
        run(tbl[0].a, o);
        cmp("after_rst", tbl[0].a, tbl[0].e, o);

        for (int i = 0; i < 40; i++) begin
            a.we = 1'($urandom); a.typ = 2'($urandom_range(0, 2)); a.sext = 1'($urandom);
            a.addr = $urandom_range(0, 5) == 0 ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
            a.wdata = $urandom; a.rd0 = $urandom; a.rd1 = $urandom;
            a.err0 = $urandom_range(0, 7) == 0; a.err1 = $urandom_range(0, 7) == 0;
            a.gd = $urandom_range(0, 2); a.lat = $urandom_range(1, 3);
            run(a, o);
            cmp($sformatf("rand%0d", i), a, model(a), o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
